// File: rtl/ff_conv_pkg.sv
// Shared flip-flop conversion helpers: S=R=1 resolution policies and the
// SR-to-T excitation function used by the TFF-based banks.
package ff_conv_pkg;

    localparam int POL_HOLD  = 0;
    localparam int POL_SET   = 1;
    localparam int POL_RESET = 2;

    typedef enum logic [1:0] {
        CMD_HOLD    = 2'b00,
        CMD_RESET   = 2'b01,
        CMD_SET     = 2'b10,
        CMD_ILLEGAL = 2'b11
    } sr_cmd_e;

    // T excitation that moves a TFF holding q to the SR-resolved next state.
    function automatic logic sr_to_t(input logic s, input logic r, input logic q, input int policy);
        logic t;
        t = 1'b0;
        case (sr_cmd_e'({s, r}))
            CMD_HOLD:    t = 1'b0;
            CMD_SET:     t = ~q;
            CMD_RESET:   t = q;
            CMD_ILLEGAL: begin
                if (policy == POL_SET) begin
                    t = ~q;
                end else if (policy == POL_RESET) begin
                    t = q;
                end else begin
                    t = 1'b0;
                end
            end
            default:     t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop primitive with asynchronous active-low reset to 0.
module tff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q ^ t;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/srff_bank_from_tff.sv
// Bank of SR flip-flops realised on tff_cell primitives, with illegal-command
// flagging (pulse, sticky, per-bit mask) and a saturating toggle-activity counter.
module srff_bank_from_tff
    import ff_conv_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int ILLEGAL_POLICY = 0,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t_dbg,
    output logic             illegal,
    output logic             illegal_sticky,
    output logic [WIDTH-1:0] illegal_mask,
    output logic [CNT_W-1:0] toggle_cnt
);

    if (ILLEGAL_POLICY < POL_HOLD || ILLEGAL_POLICY > POL_RESET) begin : g_bad_policy
        $error("srff_bank_from_tff: ILLEGAL_POLICY must be 0, 1 or 2");
    end

    logic [WIDTH-1:0] t_exc;
    logic [WIDTH-1:0] cmd_illegal;

    logic             illegal_q;
    logic             illegal_d;
    logic             sticky_q;
    logic             sticky_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        t_exc       = '0;
        cmd_illegal = '0;
        if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                t_exc[i] = sr_to_t(s[i], r[i], q[i], ILLEGAL_POLICY);
            end
            cmd_illegal = s & r;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        tff_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .t     (t_exc[g]),
            .q     (q[g])
        );
    end

    // A fresh illegal command in the clearing cycle survives the clear.
    always_comb begin
        illegal_d = |cmd_illegal;
        mask_d    = (clr_err ? '0 : mask_q) | cmd_illegal;
        sticky_d  = |mask_d;
        cnt_d     = cnt_q;
        if ((|t_exc) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
            sticky_q  <= 1'b0;
            mask_q    <= '0;
            cnt_q     <= '0;
        end else begin
            illegal_q <= illegal_d;
            sticky_q  <= sticky_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
        end
    end

    assign t_dbg          = t_exc;
    assign illegal        = illegal_q;
    assign illegal_sticky = sticky_q;
    assign illegal_mask   = mask_q;
    assign toggle_cnt     = cnt_q;

endmodule

// File: tb/tb_srff_bank_from_tff.sv
// Bench for srff_bank_from_tff: four instances (three policies, one narrow counter)
// driven in lockstep and checked every cycle against a next-state model.
module tb_srff_bank_from_tff;

    localparam int NDUT = 4;
    localparam int POL [NDUT] = '{0, 1, 2, 0};
    localparam logic [7:0] CMAX [NDUT] = '{8'd255, 8'd255, 8'd255, 8'd3};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       clr_err = 1'b0;
    logic [3:0] s = 4'b0;
    logic [3:0] r = 4'b0;

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    wire [3:0] dq    [NDUT];
    wire [3:0] dt    [NDUT];
    wire [3:0] dmask [NDUT];
    wire       dill  [NDUT];
    wire       dstk  [NDUT];
    wire [7:0] dcnt  [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int CW = (g == 3) ? 2 : 8;
        logic [CW-1:0] cnt_w;
        logic [3:0]    q_w;
        logic [3:0]    t_w;
        logic [3:0]    m_w;
        logic          i_w;
        logic          st_w;

        srff_bank_from_tff #(
            .WIDTH          (4),
            .ILLEGAL_POLICY (POL[g]),
            .CNT_W          (CW)
        ) dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .en             (en),
            .s              (s),
            .r              (r),
            .clr_err        (clr_err),
            .q              (q_w),
            .t_dbg          (t_w),
            .illegal        (i_w),
            .illegal_sticky (st_w),
            .illegal_mask   (m_w),
            .toggle_cnt     (cnt_w)
        );

        assign dq[g]    = q_w;
        assign dt[g]    = t_w;
        assign dmask[g] = m_w;
        assign dill[g]  = i_w;
        assign dstk[g]  = st_w;
        assign dcnt[g]  = 8'(cnt_w);
    end

    // Reference model: SR next-state semantics, no T excitation involved.
    logic [3:0] mq    [NDUT];
    logic [3:0] mmask [NDUT];
    logic       mill  [NDUT];
    logic       mstk  [NDUT];
    logic [7:0] mcnt  [NDUT];

    function automatic logic [3:0] next_q(input logic [3:0] cur, input logic [3:0] sv,
                                          input logic [3:0] rv, input logic ev, input int pol);
        logic [3:0] n;
        n = cur;
        if (ev) begin
            for (int i = 0; i < 4; i++) begin
                if (sv[i] && !rv[i]) n[i] = 1'b1;
                else if (!sv[i] && rv[i]) n[i] = 1'b0;
                else if (sv[i] && rv[i]) n[i] = (pol == 1) ? 1'b1 : (pol == 2) ? 1'b0 : cur[i];
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < NDUT; k++) begin
            if (!rst_n) begin
                mq[k]    <= 4'b0;
                mmask[k] <= 4'b0;
                mill[k]  <= 1'b0;
                mstk[k]  <= 1'b0;
                mcnt[k]  <= 8'd0;
            end else begin
                mq[k]    <= next_q(mq[k], s, r, en, POL[k]);
                mill[k]  <= en && ((s & r) != 4'b0);
                mmask[k] <= (clr_err ? 4'b0 : mmask[k]) | (en ? (s & r) : 4'b0);
                mstk[k]  <= |((clr_err ? 4'b0 : mmask[k]) | (en ? (s & r) : 4'b0));
                if (next_q(mq[k], s, r, en, POL[k]) != mq[k]) begin
                    mcnt[k] <= (mcnt[k] == CMAX[k]) ? mcnt[k] : mcnt[k] + 8'd1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < NDUT; k++) begin
                checkOutput($sformatf("dut%0d q", k), 8'(dq[k]), 8'(mq[k]));
                checkOutput($sformatf("dut%0d t_dbg", k), 8'(dt[k]),
                            8'(mq[k] ^ next_q(mq[k], s, r, en, POL[k])));
                checkOutput($sformatf("dut%0d illegal", k), 8'(dill[k]), 8'(mill[k]));
                checkOutput($sformatf("dut%0d sticky", k), 8'(dstk[k]), 8'(mstk[k]));
                checkOutput($sformatf("dut%0d mask", k), 8'(dmask[k]), 8'(mmask[k]));
                checkOutput($sformatf("dut%0d cnt", k), dcnt[k], mcnt[k]);
            end
        end
    end

    task automatic applyStimulus(input logic e, input logic [3:0] sv, input logic [3:0] rv,
                                 input logic c);
        en      = e;
        s       = sv;
        r       = rv;
        clr_err = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 4'b0, 4'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        logic [7:0] sat_exp [5];
        logic [3:0] pol_q   [NDUT];
        sat_exp = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
        pol_q   = '{4'b0101, 4'b1111, 4'b0000, 4'b0101};

        #1;
        doReset();
        checking = 1'b1;

        // Build q=1010, toggle_cnt=5, then reset mid-cycle.
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) applyStimulus(1'b1, 4'b1010, 4'b0000, 1'b0);
            else            applyStimulus(1'b1, 4'b0000, 4'b1010, 1'b0);
            step();
        end
        checkOutput("pre-reset q", 8'(dq[0]), 8'h0a);
        checkOutput("pre-reset cnt", dcnt[0], 8'd5);
        applyStimulus(1'b1, 4'b0, 4'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset q", 8'(dq[0]), 8'h00);
        checkOutput("async reset cnt", dcnt[0], 8'd0);
        checkOutput("async reset mask", 8'(dmask[0]), 8'h00);
        checkOutput("async reset flags", {6'b0, dill[0], dstk[0]}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Set / reset / hold
        applyStimulus(1'b1, 4'b0011, 4'b0000, 1'b0); step();
        checkOutput("set q", 8'(dq[0]), 8'h03);
        checkOutput("set cnt", dcnt[0], 8'd1);
        applyStimulus(1'b1, 4'b0000, 4'b0001, 1'b0); step();
        checkOutput("reset q", 8'(dq[0]), 8'h02);
        checkOutput("reset cnt", dcnt[0], 8'd2);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0); step();
        checkOutput("hold q", 8'(dq[0]), 8'h02);
        checkOutput("hold cnt", dcnt[0], 8'd2);

        // Redundant set
        applyStimulus(1'b1, 4'b0010, 4'b0000, 1'b0);
        #1;
        checkOutput("redundant t_dbg", 8'(dt[0]), 8'h00);
        step();
        checkOutput("redundant q", 8'(dq[0]), 8'h02);
        checkOutput("redundant cnt", dcnt[0], 8'd2);

        // Illegal command under each policy
        doReset();
        applyStimulus(1'b1, 4'b0101, 4'b0000, 1'b0); step();
        applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b0); step();
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("illegal q pol dut%0d", k), 8'(dq[k]), 8'(pol_q[k]));
            checkOutput($sformatf("illegal pulse dut%0d", k), 8'(dill[k]), 8'd1);
            checkOutput($sformatf("illegal mask dut%0d", k), 8'(dmask[k]), 8'h0f);
            checkOutput($sformatf("illegal sticky dut%0d", k), 8'(dstk[k]), 8'd1);
        end
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0); step();
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("pulse end dut%0d", k), 8'(dill[k]), 8'd0);
            checkOutput($sformatf("mask kept dut%0d", k), 8'(dmask[k]), 8'h0f);
        end

        // clr_err collides with a new illegal command
        applyStimulus(1'b1, 4'b0100, 4'b0100, 1'b1); step();
        checkOutput("collision mask", 8'(dmask[0]), 8'h04);
        checkOutput("collision sticky", 8'(dstk[0]), 8'd1);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1); step();
        checkOutput("clear mask", 8'(dmask[0]), 8'h00);
        checkOutput("clear sticky", 8'(dstk[0]), 8'd0);

        // Enable gating and counter saturation on the narrow-counter instance
        doReset();
        applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b0); step();
        checkOutput("en0 q", 8'(dq[3]), 8'h00);
        checkOutput("en0 cnt", dcnt[3], 8'd0);
        checkOutput("en0 illegal", 8'(dill[3]), 8'd0);
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b0);
            else            applyStimulus(1'b1, 4'b0000, 4'b1111, 1'b0);
            step();
            checkOutput($sformatf("sat cnt %0d", i), dcnt[3], sat_exp[i]);
        end

        applyStimulus(1'b0, 4'b0, 4'b0, 1'b0);
        step();
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
